// File: rtl/mem_resp.sv
// mem_resp: memory-side TXB responder owning a single-word store with a fixed access latency.
// Optional build macro MEM_RESP_STALL_EN adds LFSR-driven back-pressure and protocol assertions.

package mem_resp_pkg;
  typedef enum logic {TX_RD = 1'b0, TX_WR = 1'b1} tx_kind_t;

  typedef struct packed {
    logic [1:0] core_addr;
    logic [1:0] mem_addr;
    tx_kind_t   kind;
    logic       acq_rel;
    logic [7:0] data;
  } tx_t;
endpackage

module mem_resp
  import mem_resp_pkg::*;
#(
  parameter logic [1:0]  MEM_ADDR = '0,
  parameter int unsigned LAT      = 2,
  parameter logic [7:0]  INIT_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_src_rdy,
  output logic req_tgt_rdy,
  input  tx_t  req_tx,
  output logic rsp_src_rdy,
  input  logic rsp_tgt_rdy,
  output tx_t  rsp_tx
);

  localparam int CW = (LAT == 0) ? 1 : $clog2(LAT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    mem_word;
  tx_t           hold;
  logic          run;
  logic          accept_ok;
  logic          deliver_ok;
  logic          req_fire;
  logic          rsp_fire;

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci form of x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'h5A;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign accept_ok  = lfsr[0];
  assign deliver_ok = lfsr[1];
`else
  assign accept_ok  = 1'b1;
  assign deliver_ok = 1'b1;
`endif

  // run keeps tgt_rdy low until the first edge after reset release.
  assign req_tgt_rdy = run && (state == IDLE) && accept_ok;
  assign req_fire    = req_src_rdy && req_tgt_rdy;
  assign rsp_src_rdy = (state == RESP);
  assign rsp_fire    = rsp_src_rdy && rsp_tgt_rdy && deliver_ok;
  assign rsp_tx      = hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  // NOTE: the store is a single register, not an array, so it can take a reset
  // value cheaply; an array-based store would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_word <= INIT_VAL;
      hold     <= '0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (req_fire) begin
            cnt <= CW'(LAT);
            if (req_tx.kind == TX_WR) begin
              mem_word <= req_tx.data;
              hold     <= req_tx;
            end else begin
              hold <= '{core_addr: req_tx.core_addr, mem_addr: req_tx.mem_addr,
                        kind: req_tx.kind, acq_rel: req_tx.acq_rel, data: mem_word};
            end
            state <= (LAT == 0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= RESP;
        end
        RESP: begin
          if (rsp_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESP_STALL_EN
  logic stalled_q;
  tx_t  rsp_tx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stalled_q <= 1'b0;
      rsp_tx_q  <= '0;
    end else begin
      stalled_q <= rsp_src_rdy && !rsp_fire;
      rsp_tx_q  <= rsp_tx;
      if (req_fire) begin
        assert (state == IDLE) else $error("req transfer outside IDLE");
        assert (req_tx.mem_addr == MEM_ADDR) else $error("req mem_addr does not match MEM_ADDR");
      end
      if (stalled_q) begin
        assert (rsp_src_rdy && rsp_tx == rsp_tx_q) else $error("rsp changed while stalled");
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed table and corner sequences for mem_resp (LAT=2 and LAT=0 instances),
// plus a randomized run checked against a serial memory model.

module tb_mem_resp;
  import mem_resp_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic req_src_rdy, req_tgt_rdy, rsp_src_rdy, rsp_tgt_rdy;
  tx_t  req_tx, rsp_tx;
  logic req_src_z, req_tgt_z, rsp_src_z, rsp_tgt_z;
  tx_t  req_tx_z, rsp_tx_z;

  mem_resp #(.MEM_ADDR(2'd0), .LAT(LAT), .INIT_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .req_src_rdy(req_src_rdy), .req_tgt_rdy(req_tgt_rdy), .req_tx(req_tx),
    .rsp_src_rdy(rsp_src_rdy), .rsp_tgt_rdy(rsp_tgt_rdy), .rsp_tx(rsp_tx)
  );

  mem_resp #(.MEM_ADDR(2'd0), .LAT(0), .INIT_VAL(8'h00)) dut_z (
    .clk(clk), .rst(rst),
    .req_src_rdy(req_src_z), .req_tgt_rdy(req_tgt_z), .req_tx(req_tx_z),
    .rsp_src_rdy(rsp_src_z), .rsp_tgt_rdy(rsp_tgt_z), .rsp_tx(rsp_tx_z)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // LAT=0 instance: log cycles of accepts and of response-valid.
  bit z_mon = 1'b0;
  int acc_z[$];
  int rsp_z[$];
  always @(negedge clk) begin
    #2;
    if (z_mon) begin
      if (req_src_z && req_tgt_z) acc_z.push_back(cyc);
      if (rsp_src_z)              rsp_z.push_back(cyc);
    end
  end

  typedef struct {
    tx_kind_t   kind;
    logic [1:0] core;
    logic       acq;
    logic [7:0] data;
    logic [7:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tx_t mk(input logic [1:0] core, input logic [1:0] mem,
                             input tx_kind_t kind, input logic acq, input logic [7:0] data);
    tx_t t;
    t.core_addr = core;
    t.mem_addr  = mem;
    t.kind      = kind;
    t.acq_rel   = acq;
    t.data      = data;
    return t;
  endfunction

  // NOTE: bench drives use blocking assignments at the falling edge, well
  // away from the rising edge where the DUT samples them.
  task automatic do_reset();
    rst = 1'b0;
    req_src_rdy = 1'b0; req_tx = '0; rsp_tgt_rdy = 1'b1;
    req_src_z = 1'b0;   req_tx_z = '0; rsp_tgt_z = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the falling edge just after the accepting rising edge.
  task automatic send(input tx_t tx);
    bit ok = 1'b0;
    req_tx = tx;
    req_src_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (req_tgt_rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_src_rdy = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int waited);
    waited = 0;
    while (!rsp_src_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic expect_rsp(input tx_t exp, input string tag);
    int waited;
    wait_rsp(waited);
    check({tag, "_lat"}, waited, LAT);
    check({tag, "_tx"}, rsp_tx, exp);
    @(negedge clk);
    check({tag, "_done"}, rsp_src_rdy, 1'b0);
  endtask

  task automatic random_run();
    tx_t        exp_q[$];
    logic [7:0] model_mem = 8'h00;
    int         n_rsp = 0;
    do_reset();
    fork
      begin : driver
        for (int i = 0; i < 50; i++) begin
          tx_t t;
          t = mk(2'($urandom_range(0, 3)), 2'd0, tx_kind_t'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
`ifndef MEM_RESP_STALL_EN
          t.mem_addr = 2'($urandom_range(0, 3));
`endif
          exp_q.push_back(mk(t.core_addr, t.mem_addr, t.kind, t.acq_rel,
                             (t.kind == TX_WR) ? t.data : model_mem));
          if (t.kind == TX_WR) model_mem = t.data;
          send(t);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin : sink_ready
        for (int g = 0; g < 5000 && n_rsp < 50; g++) begin
          @(negedge clk);
          rsp_tgt_rdy = 1'($urandom_range(0, 1));
        end
        rsp_tgt_rdy = 1'b1;
      end
      begin : monitor
        logic prev = 1'b0;
        tx_t  cur  = '0;
        for (int g = 0; g < 5000 && n_rsp < 50; g++) begin
          @(negedge clk);
          if (rsp_src_rdy && !prev) begin
            cur = rsp_tx;
            n_rsp++;
            if (exp_q.size() == 0) check("rand_extra_rsp", 32'd1, 32'd0);
            else check("rand_rsp_tx", cur, exp_q.pop_front());
          end else if (rsp_src_rdy) begin
            check("rand_rsp_stable", rsp_tx, cur);
          end
          prev = rsp_src_rdy;
        end
      end
    join
    check("rand_rsp_count", n_rsp, 50);
    check("rand_pending", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
`ifndef MEM_RESP_STALL_EN
    vec_t vecs[5];
    int   waited;
    int   highs;
    tx_t  held;

    vecs[0] = '{TX_RD, 2'd0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{TX_WR, 2'd1, 1'b0, 8'hA5, 8'hA5};
    vecs[2] = '{TX_RD, 2'd1, 1'b0, 8'h11, 8'hA5};
    vecs[3] = '{TX_WR, 2'd2, 1'b1, 8'h3C, 8'h3C};
    vecs[4] = '{TX_RD, 2'd3, 1'b1, 8'hFF, 8'h3C};

    // Reset values, including the one-cycle delay on tgt_rdy after release.
    req_src_rdy = 1'b0; req_tx = '0; rsp_tgt_rdy = 1'b1;
    req_src_z = 1'b0;   req_tx_z = '0; rsp_tgt_z = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_tgt_rdy", req_tgt_rdy, 1'b0);
    check("rst_rsp_src_rdy", rsp_src_rdy, 1'b0);
    check("rst_rsp_tx", rsp_tx, '0);
    rst = 1'b1;
    check("rel_req_tgt_rdy_0", req_tgt_rdy, 1'b0);
    @(negedge clk);
    check("rel_req_tgt_rdy_1", req_tgt_rdy, 1'b1);

    for (int i = 0; i < 5; i++) begin
      send(mk(vecs[i].core, 2'd0, vecs[i].kind, vecs[i].acq, vecs[i].data));
      expect_rsp(mk(vecs[i].core, 2'd0, vecs[i].kind, vecs[i].acq, vecs[i].exp_data),
                 $sformatf("vec%0d", i));
    end

    // Consumer back-pressure in RESP while another request waits.
    rsp_tgt_rdy = 1'b0;
    send(mk(2'd2, 2'd0, TX_RD, 1'b0, 8'h00));
    wait_rsp(waited);
    check("bp_lat", waited, LAT);
    held = rsp_tx;
    check("bp_tx", held, mk(2'd2, 2'd0, TX_RD, 1'b0, 8'h3C));
    req_tx = mk(2'd3, 2'd1, TX_WR, 1'b0, 8'h5E);
    req_src_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_src_hold", rsp_src_rdy, 1'b1);
      check("bp_tx_hold", rsp_tx, held);
      check("bp_req_blocked", req_tgt_rdy, 1'b0);
    end
    rsp_tgt_rdy = 1'b1;
    @(negedge clk);
    check("bp_released", rsp_src_rdy, 1'b0);
    check("bp_req_ready", req_tgt_rdy, 1'b1);
    @(negedge clk);
    req_src_rdy = 1'b0;
    expect_rsp(mk(2'd3, 2'd1, TX_WR, 1'b0, 8'h5E), "bp_next");

    // Reset during BUSY drops the write and restores the initial word.
    send(mk(2'd1, 2'd0, TX_WR, 1'b0, 8'h3C));
    rst = 1'b0;
    @(negedge clk);
    check("midrst_src_rdy", rsp_src_rdy, 1'b0);
    check("midrst_tgt_rdy", req_tgt_rdy, 1'b0);
    rst = 1'b1;
    highs = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (rsp_src_rdy) highs++;
    end
    check("midrst_no_rsp", highs, 0);
    send(mk(2'd0, 2'd0, TX_RD, 1'b0, 8'h00));
    expect_rsp(mk(2'd0, 2'd0, TX_RD, 1'b0, 8'h00), "midrst_rd");

    // LAT=0: response the cycle after accept, accepts two cycles apart.
    do_reset();
    acc_z.delete();
    rsp_z.delete();
    req_tx_z = mk(2'd1, 2'd0, TX_RD, 1'b0, 8'h00);
    rsp_tgt_z = 1'b1;
    req_src_z = 1'b1;
    z_mon = 1'b1;
    repeat (9) @(negedge clk);
    req_src_z = 1'b0;
    repeat (3) @(negedge clk);
    z_mon = 1'b0;
    check("z_accepts_ge3", 32'(acc_z.size() >= 3), 32'd1);
    check("z_rsp_count", rsp_z.size(), acc_z.size());
    for (int i = 0; i < acc_z.size(); i++) begin
      if (i < rsp_z.size()) check("z_rsp_next_cycle", rsp_z[i], acc_z[i] + 1);
      if (i > 0)            check("z_accept_period", acc_z[i] - acc_z[i-1], 2);
    end
    check("z_rsp_data", rsp_tx_z.data, 8'h00);
`endif

    random_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
